// File: rtl/vend_pkg.sv
// vend_pkg: definitions shared by the vending panel arbiter and its stock counters.
// Holds the product codes, their prices, the arbiter state encoding, the stock
// counter width, and a helper that tells whether a selected product can be sold.
package vend_pkg;

  localparam int STOCK_W = 4;

  localparam logic [1:0] P_NONE = 2'b00;
  localparam logic [1:0] P15    = 2'b01;
  localparam logic [1:0] P20    = 2'b10;
  localparam logic [1:0] P25    = 2'b11;

  localparam logic [4:0] PRICE_P15 = 5'd15;
  localparam logic [4:0] PRICE_P20 = 5'd20;
  localparam logic [4:0] PRICE_P25 = 5'd25;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // A select code is a valid request only for a real product that still has stock.
  function automatic logic prod_avail(input logic [1:0] sel, input logic [2:0] sold_out);
    logic avail;
    case (sel)
      P15:     avail = ~sold_out[0];
      P20:     avail = ~sold_out[1];
      P25:     avail = ~sold_out[2];
      default: avail = 1'b0;
    endcase
    return avail;
  endfunction

endpackage

// File: rtl/vend_stock_counter.sv
// vend_stock_counter: stock count for one product.
// Ports: clk/rst (sync, active-high), load reloads INIT, dec decrements with
// saturation at zero (load wins over dec), empty is high while the count is zero.
module vend_stock_counter
  import vend_pkg::*;
#(
  parameter logic [STOCK_W-1:0] INIT = 4'd8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic empty
);

  logic [STOCK_W-1:0] count_r;

  // Stock register: reset/restock reload, otherwise saturating decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= INIT;
    end else if (load) begin
      count_r <= INIT;
    end else if (dec && (count_r != {STOCK_W{1'b0}})) begin
      count_r <= count_r - STOCK_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign empty = (count_r == {STOCK_W{1'b0}});

endmodule

// File: rtl/vend_panel_arbiter.sv
// vend_panel_arbiter: shares one vending_fsm between two customer panels.
// Ports: clk, rst (sync, active-high); p0_*/p1_* panel select, coin and cancel
// inputs; restock reloads all stock; fsm_dispense/fsm_refund/fsm_product_id are
// completion reports from the vending_fsm; fsm_select/fsm_coin_5/fsm_coin_10/
// fsm_cancel are registered requests to it; grant is the one-hot session owner;
// sold_out flags empty products; timeout_err is a sticky drain-watchdog flag.
module vend_panel_arbiter
  import vend_pkg::*;
#(
  parameter int TIMEOUT    = 64,
  parameter int STOCK_INIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] p0_select,
  input  logic [1:0] p1_select,
  input  logic       p0_coin_5,
  input  logic       p0_coin_10,
  input  logic       p0_cancel,
  input  logic       p1_coin_5,
  input  logic       p1_coin_10,
  input  logic       p1_cancel,
  input  logic       restock,
  input  logic       fsm_dispense,
  input  logic       fsm_refund,
  input  logic [1:0] fsm_product_id,
  output logic [1:0] fsm_select,
  output logic       fsm_coin_5,
  output logic       fsm_coin_10,
  output logic       fsm_cancel,
  output logic [1:0] grant,
  output logic [2:0] sold_out,
  output logic       timeout_err
);

  localparam int            CW         = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] IDLE_LIMIT = CW'(TIMEOUT - 1);

  state_t        state_r;
  logic [1:0]    grant_r;
  logic [1:0]    sel_r;
  logic [1:0]    fsm_select_r;
  logic          fsm_coin_5_r;
  logic          fsm_coin_10_r;
  logic          fsm_cancel_r;
  logic          last_r;        // panel granted last: 1 gives panel 0 priority
  logic [CW-1:0] idle_cnt_r;    // idle counter in ACTIVE, watchdog in DRAIN
  logic          timeout_err_r;

  logic [2:0] empty_s;
  logic [2:0] dec_s;
  logic       p0_req_s;
  logic       p1_req_s;
  logic       win_p1_s;
  logic       own_c5_s;
  logic       own_c10_s;
  logic       own_cancel_s;
  logic       fwd_c5_s;
  logic       fwd_c10_s;
  logic       done_s;

  for (genvar k = 0; k < 3; k++) begin : g_stock
    assign dec_s[k] = fsm_dispense && (fsm_product_id == 2'(k + 1));
    vend_stock_counter #(
      .INIT (STOCK_W'(STOCK_INIT))
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .load  (restock),
      .dec   (dec_s[k]),
      .empty (empty_s[k])
    );
  end

  // Request qualification, round-robin winner and owner input selection.
  always_comb begin
    p0_req_s     = (p0_select != P_NONE) && prod_avail(p0_select, empty_s);
    p1_req_s     = (p1_select != P_NONE) && prod_avail(p1_select, empty_s);
    // Panel 1 wins when alone, or when both request and panel 0 was granted last.
    win_p1_s     = p1_req_s && (!p0_req_s || !last_r);
    own_c5_s     = grant_r[1] ? p1_coin_5  : p0_coin_5;
    own_c10_s    = grant_r[1] ? p1_coin_10 : p0_coin_10;
    own_cancel_s = grant_r[1] ? p1_cancel  : p0_cancel;
    // Conflicting coins cancel each other; cancel suppresses any coin.
    fwd_c5_s     = own_c5_s && !own_c10_s && !own_cancel_s;
    fwd_c10_s    = own_c10_s && !own_c5_s && !own_cancel_s;
    done_s       = fsm_dispense || fsm_refund;
  end

  // Session state machine, forwarded pulses and watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      grant_r       <= 2'b00;
      sel_r         <= 2'b00;
      fsm_select_r  <= 2'b00;
      fsm_coin_5_r  <= 1'b0;
      fsm_coin_10_r <= 1'b0;
      fsm_cancel_r  <= 1'b0;
      last_r        <= 1'b1;
      idle_cnt_r    <= {CW{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      fsm_select_r  <= 2'b00;
      fsm_coin_5_r  <= 1'b0;
      fsm_coin_10_r <= 1'b0;
      fsm_cancel_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (p0_req_s || p1_req_s) begin
            grant_r    <= win_p1_s ? 2'b10 : 2'b01;
            sel_r      <= win_p1_s ? p1_select : p0_select;
            idle_cnt_r <= {CW{1'b0}};
            state_r    <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          fsm_select_r <= sel_r;
          state_r      <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (done_s) begin
            last_r  <= grant_r[1];
            grant_r <= 2'b00;
            state_r <= ST_IDLE;
          end else begin
            fsm_coin_5_r  <= fwd_c5_s;
            fsm_coin_10_r <= fwd_c10_s;
            if (fwd_c5_s || fwd_c10_s) begin
              fsm_cancel_r <= own_cancel_s;
              idle_cnt_r   <= {CW{1'b0}};
            end else if (idle_cnt_r == IDLE_LIMIT) begin
              // Abandoned session: cancel on the customer's behalf and wait.
              fsm_cancel_r <= 1'b1;
              idle_cnt_r   <= {CW{1'b0}};
              state_r      <= ST_DRAIN;
            end else begin
              fsm_cancel_r <= own_cancel_s;
              idle_cnt_r   <= idle_cnt_r + CW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (done_s) begin
            last_r  <= grant_r[1];
            grant_r <= 2'b00;
            state_r <= ST_IDLE;
          end else if (idle_cnt_r == IDLE_LIMIT) begin
            // vending_fsm never acknowledged the cancel: free the machine anyway.
            last_r        <= grant_r[1];
            grant_r       <= 2'b00;
            timeout_err_r <= 1'b1;
            state_r       <= ST_IDLE;
          end else begin
            idle_cnt_r <= idle_cnt_r + CW'(1);
          end
        end
        default: begin
          grant_r <= 2'b00;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign fsm_select  = fsm_select_r;
  assign fsm_coin_5  = fsm_coin_5_r;
  assign fsm_coin_10 = fsm_coin_10_r;
  assign fsm_cancel  = fsm_cancel_r;
  assign grant       = grant_r;
  assign sold_out    = empty_s;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_vend_panel_arbiter.sv
// Bench for vend_panel_arbiter: directed stimulus pushes expected output events
// into a queue; a monitor pops and compares whenever the DUT shows a pulse or a
// grant change. Static values (stock, flags, state) are checked inline.
module tb_vend_panel_arbiter;
  import vend_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] p0_select, p1_select;
  logic       p0_coin_5, p0_coin_10, p0_cancel;
  logic       p1_coin_5, p1_coin_10, p1_cancel;
  logic       restock, fsm_dispense, fsm_refund;
  logic [1:0] fsm_product_id;
  logic [1:0] fsm_select;
  logic       fsm_coin_5, fsm_coin_10, fsm_cancel;
  logic [1:0] grant;
  logic [2:0] sold_out;
  logic       timeout_err;

  typedef struct packed {
    logic [1:0] grant;
    logic [1:0] sel;
    logic       c5;
    logic       c10;
    logic       cn;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs;
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         mon_en   = 1'b0;
  logic [1:0] prev_grant = 2'b00;

  always #5 clk = ~clk;

  vend_panel_arbiter #(.TIMEOUT(64), .STOCK_INIT(8)) u_dut (
    .clk(clk), .rst(rst),
    .p0_select(p0_select), .p1_select(p1_select),
    .p0_coin_5(p0_coin_5), .p0_coin_10(p0_coin_10), .p0_cancel(p0_cancel),
    .p1_coin_5(p1_coin_5), .p1_coin_10(p1_coin_10), .p1_cancel(p1_cancel),
    .restock(restock), .fsm_dispense(fsm_dispense), .fsm_refund(fsm_refund),
    .fsm_product_id(fsm_product_id),
    .fsm_select(fsm_select), .fsm_coin_5(fsm_coin_5), .fsm_coin_10(fsm_coin_10),
    .fsm_cancel(fsm_cancel), .grant(grant), .sold_out(sold_out),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] g, input logic [1:0] s,
                           input logic c5, input logic c10, input logic cn);
    ev_t e;
    e.grant = g; e.sel = s; e.c5 = c5; e.c10 = c10; e.cn = cn;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any pulse or grant change is an event that must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        obs = {grant, fsm_select, fsm_coin_5, fsm_coin_10, fsm_cancel};
        if ((obs.sel != 2'b00) || obs.c5 || obs.c10 || obs.cn || (grant != prev_grant)) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got %0h, expected no event", obs);
          end else begin
            chk("event", 32'(obs), 32'(exp_q.pop_front()));
          end
        end
        prev_grant = grant;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int k;
    rst = 1'b1;
    p0_select = 2'b00; p1_select = 2'b00;
    p0_coin_5 = 1'b0; p0_coin_10 = 1'b0; p0_cancel = 1'b0;
    p1_coin_5 = 1'b0; p1_coin_10 = 1'b0; p1_cancel = 1'b0;
    restock = 1'b0; fsm_dispense = 1'b0; fsm_refund = 1'b0; fsm_product_id = 2'b00;
    cyc(2);
    rst = 1'b0;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_fsm_out", 32'({fsm_select, fsm_coin_5, fsm_coin_10, fsm_cancel}), 32'h0);
    chk("reset_sold_out", 32'(sold_out), 32'h0);
    chk("reset_timeout_err", 32'(timeout_err), 32'h0);
    prev_grant = grant;
    mon_en = 1'b1;
    cyc(2);

    // Simultaneous requests after reset: panel 0 wins, then panel 1.
    p0_select = 2'b10; p1_select = 2'b11;
    expect_ev(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(1); p0_select = 2'b00; p1_select = 2'b00;
    chk("rr_first_grant", 32'(grant), 32'h1);
    expect_ev(2'b01, 2'b10, 1'b0, 1'b0, 1'b0);
    cyc(1);
    p1_coin_10 = 1'b1;
    cyc(1); p1_coin_10 = 1'b0;
    chk("nonowner_coin10", 32'(fsm_coin_10), 32'h0);
    p0_coin_5 = 1'b1; p0_coin_10 = 1'b1;
    cyc(1); p0_coin_5 = 1'b0; p0_coin_10 = 1'b0;
    chk("both_coins_blocked", 32'({fsm_coin_5, fsm_coin_10}), 32'h0);
    p0_cancel = 1'b1; p0_coin_5 = 1'b1;
    expect_ev(2'b01, 2'b00, 1'b0, 1'b0, 1'b1);
    cyc(1); p0_cancel = 1'b0; p0_coin_5 = 1'b0;
    fsm_dispense = 1'b1; fsm_product_id = 2'b10;
    expect_ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(1); fsm_dispense = 1'b0; fsm_product_id = 2'b00;
    chk("stock_p20_after_dispense", 32'(u_dut.g_stock[1].u_cnt.count_r), 32'd7);
    p0_select = 2'b10; p1_select = 2'b11;
    expect_ev(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(1); p0_select = 2'b00; p1_select = 2'b00;
    chk("rr_second_grant", 32'(grant), 32'h2);
    expect_ev(2'b10, 2'b11, 1'b0, 1'b0, 1'b0);
    cyc(1);
    fsm_refund = 1'b1;
    expect_ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(1); fsm_refund = 1'b0;

    // Basic purchase on panel 0.
    p0_select = 2'b01;
    expect_ev(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(1); p0_select = 2'b00;
    expect_ev(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc(1);
    chk("fsm_select_pulse", 32'(fsm_select), 32'h1);
    p0_coin_10 = 1'b1;
    expect_ev(2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
    cyc(1); p0_coin_10 = 1'b0;
    chk("fsm_select_one_cycle", 32'(fsm_select), 32'h0);
    p0_coin_5 = 1'b1;
    expect_ev(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
    cyc(1); p0_coin_5 = 1'b0;
    fsm_dispense = 1'b1; fsm_product_id = 2'b01;
    expect_ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(1); fsm_dispense = 1'b0; fsm_product_id = 2'b00;
    chk("stock_p15_after_dispense", 32'(u_dut.g_stock[0].u_cnt.count_r), 32'd7);

    // Panel 1 abandons its session: auto-cancel after 64 idle cycles, then refund.
    p1_select = 2'b01;
    expect_ev(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(1); p1_select = 2'b00;
    expect_ev(2'b10, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc(1);
    p1_coin_10 = 1'b1;
    expect_ev(2'b10, 2'b00, 1'b0, 1'b1, 1'b0);
    cyc(1); p1_coin_10 = 1'b0;
    expect_ev(2'b10, 2'b00, 1'b0, 1'b0, 1'b1);
    for (k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (fsm_cancel) break;
    end
    chk("idle_timeout_cycles", 32'(k), 32'd64);
    chk("state_drain", 32'(u_dut.state_r), 32'(ST_DRAIN));
    p1_coin_5 = 1'b1;
    cyc(1); p1_coin_5 = 1'b0; p1_coin_10 = 1'b1;
    cyc(1); p1_coin_10 = 1'b0;
    chk("drain_coins_ignored", 32'({fsm_coin_5, fsm_coin_10, fsm_cancel}), 32'h0);
    fsm_refund = 1'b1;
    expect_ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(1); fsm_refund = 1'b0;
    chk("state_idle_after_refund", 32'(u_dut.state_r), 32'(ST_IDLE));
    chk("no_timeout_err_yet", 32'(timeout_err), 32'h0);

    // Drain watchdog: no completion ever arrives.
    p0_select = 2'b01;
    expect_ev(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(1); p0_select = 2'b00;
    expect_ev(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc(1);
    expect_ev(2'b01, 2'b00, 1'b0, 1'b0, 1'b1);
    for (k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (fsm_cancel) break;
    end
    chk("active_idle_cycles", 32'(k), 32'd64);
    expect_ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    for (k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (grant == 2'b00) break;
    end
    chk("drain_watchdog_cycles", 32'(k), 32'd64);
    chk("timeout_err_set", 32'(timeout_err), 32'h1);

    // Sell out product 11, then restock (restock beats a coincident dispense).
    fsm_dispense = 1'b1; fsm_product_id = 2'b11;
    cyc(7);
    chk("sold_out_after_7", 32'(sold_out), 32'h0);
    cyc(1);
    chk("sold_out_after_8", 32'(sold_out), 32'h4);
    cyc(1); fsm_dispense = 1'b0; fsm_product_id = 2'b00;
    chk("stock_p25_saturated", 32'(u_dut.g_stock[2].u_cnt.count_r), 32'd0);
    p0_select = 2'b11;
    cyc(1); p0_select = 2'b00;
    cyc(1);
    chk("sold_out_no_grant", 32'(grant), 32'h0);
    restock = 1'b1; fsm_dispense = 1'b1; fsm_product_id = 2'b01;
    cyc(1); restock = 1'b0; fsm_dispense = 1'b0; fsm_product_id = 2'b00;
    chk("sold_out_after_restock", 32'(sold_out), 32'h0);
    chk("restock_beats_dec", 32'(u_dut.g_stock[0].u_cnt.count_r), 32'd8);
    chk("restock_p25", 32'(u_dut.g_stock[2].u_cnt.count_r), 32'd8);

    // Reset in the middle of an active session.
    fsm_dispense = 1'b1; fsm_product_id = 2'b01;
    cyc(1); fsm_dispense = 1'b0; fsm_product_id = 2'b00;
    chk("idle_dispense_decrements", 32'(u_dut.g_stock[0].u_cnt.count_r), 32'd7);
    p0_select = 2'b01;
    expect_ev(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(1); p0_select = 2'b00;
    expect_ev(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc(1);
    p0_coin_5 = 1'b1;
    expect_ev(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
    cyc(1); p0_coin_5 = 1'b0;
    p0_coin_10 = 1'b1; rst = 1'b1;
    expect_ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(1); p0_coin_10 = 1'b0; rst = 1'b0;
    chk("midreset_grant", 32'(grant), 32'h0);
    chk("midreset_fsm_out", 32'({fsm_select, fsm_coin_5, fsm_coin_10, fsm_cancel}), 32'h0);
    chk("midreset_stock", 32'(u_dut.g_stock[0].u_cnt.count_r), 32'd8);
    chk("midreset_timeout_err", 32'(timeout_err), 32'h0);
    chk("midreset_state", 32'(u_dut.state_r), 32'(ST_IDLE));
    cyc(1);
    chk("post_reset_no_pulse", 32'({fsm_select, fsm_coin_5, fsm_coin_10, fsm_cancel}), 32'h0);

    cyc(3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_panel_arbiter.md
VEND_PANEL_ARBITER -- requirements
Module: vend_panel_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: idle cycles allowed in an owned session before an automatic cancel.
REQ-002 Parameter STOCK_INIT, default 8: per-product stock loaded at reset and on restock; 4-bit counters, so STOCK_INIT SHALL be 1..15.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 p0_select, p1_select  in  2 each  panel product button; 2'b00 = none; 01/10/11 = products priced 15/20/25.
REQ-006 p0_coin_5, p0_coin_10, p0_cancel, p1_coin_5, p1_coin_10, p1_cancel  in  1 each  panel coin and cancel pulses.
REQ-007 restock  in  1  pulse; reloads all stock counters.
REQ-008 fsm_dispense, fsm_refund  in  1 each  completion pulses from the shared vending_fsm.
REQ-009 fsm_product_id  in  2  product dispensed, valid while fsm_dispense=1.
REQ-010 fsm_select  out  2  select forwarded to vending_fsm.
REQ-011 fsm_coin_5, fsm_coin_10, fsm_cancel  out  1 each  forwarded pulses to vending_fsm.
REQ-012 grant  out  2  one-hot session owner; 2'b00 = free.
REQ-013 sold_out  out  3  bit k-1 = 1 when product k stock is 0.
REQ-014 timeout_err  out  1  sticky; set when a drain watchdog expires.

Function
REQ-015 States SHALL be IDLE, SELECT, ACTIVE and DRAIN.
REQ-016 IDLE: a panel requests when its select is nonzero and that product is not sold out; requests for sold-out products SHALL be ignored, with no grant.
REQ-017 IDLE with one valid request: SHALL set grant to that panel, latch its select, and go to SELECT.
REQ-018 IDLE with two simultaneous valid requests: round-robin; the panel not granted last wins; after reset, panel 0 wins.
REQ-019 SELECT: SHALL drive fsm_select = latched code for exactly one cycle, then go to ACTIVE; all outputs are registered.
REQ-020 ACTIVE: owner coin_5/coin_10/cancel SHALL be forwarded with 1-cycle latency as 1-cycle pulses; non-owner inputs SHALL be ignored.
REQ-021 Owner coin_5 and coin_10 in the same cycle: neither is forwarded, and the idle counter is not reset.
REQ-022 Owner cancel together with a coin: only cancel is forwarded.
REQ-023 Idle counter: cleared on grant and on each forwarded coin; increments otherwise in ACTIVE.
REQ-024 Idle counter reaching TIMEOUT-1: SHALL pulse fsm_cancel for one cycle and go to DRAIN.
REQ-025 ACTIVE or DRAIN, fsm_dispense or fsm_refund=1: SHALL return to IDLE next cycle, with grant=00 and the last-grant pointer updated.
REQ-026 DRAIN: owner inputs are ignored.
REQ-027 DRAIN exceeding TIMEOUT cycles without completion: SHALL force IDLE and set timeout_err.
REQ-028 fsm_dispense: SHALL decrement the stock of fsm_product_id, saturating at 0; a dispense arriving in IDLE still decrements.
REQ-029 restock coincident with a decrement: restock wins, and all counters become STOCK_INIT.
REQ-030 sold_out is combinational from the counters and updates the cycle after a change.

Reset
REQ-031 rst SHALL force the following regardless of state, including mid-session: state=IDLE, grant=00, all fsm_* outputs 0, idle counter 0, last-grant pointer giving panel 0 priority, stock counters=STOCK_INIT, timeout_err=0.
REQ-032 No forwarded pulse SHALL be emitted in the cycle after reset deasserts.

Structure
REQ-033 Shared package vend_pkg SHALL hold the product codes (P15=01, P20=10, P25=11), prices, the state enum and the stock width.
REQ-034 Sub-module vend_stock_counter (one instance per product) SHALL provide load, decrement-saturate and empty flag.

Verification
REQ-035 Bench SHALL cover: p0_select=01 at t0 -> grant=01 at t0+1; fsm_select=01 for one cycle at t0+2; p0 coin_10 and coin_5 forwarded 1 cycle later; fsm_dispense with id=01 -> grant=00 and stock[1]=7.
REQ-036 Bench SHALL cover: p0_select=10 and p1_select=11 in the same cycle after reset -> grant=01; after release, repeat the same -> grant=10.
REQ-037 Bench SHALL cover: owner p1 inserts coin_10 then idles for 64 cycles -> a single fsm_cancel pulse, state DRAIN, and p1 coins ignored; fsm_refund -> IDLE.
REQ-038 Bench SHALL cover: 8 dispenses of product 11 -> sold_out=100; p0_select=11 -> no grant; restock -> sold_out=000.
REQ-039 Bench SHALL cover: during ACTIVE, p1 (non-owner) coin_10 -> no fsm_coin_10; owner coin_5 and coin_10 in the same cycle -> no forward.
REQ-040 Bench SHALL cover: rst asserted mid-ACTIVE -> next cycle grant=00, fsm_* outputs=0, stock restored to 8.
